ram_init_sequencer: RTL and testbench

//   Parametrised power-on loader for the CPU data RAM. After reset it writes INIT_COUNT

---
 rtl/ram_init_sequencer.sv | 145 ++++++++++++++
 tb/tb_ram_init_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_init_sequencer.sv
// ram_init_sequencer
//   Power-on loader for the CPU data RAM. After reset it copies INIT_COUNT words
//   from a combinational init table into RAM addresses 0..INIT_COUNT-1, optionally
//   reads them back and compares, then hands the RAM port over to the user side.
//   A start pulse in DONE or ERROR reruns the whole sequence.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   BOOT   | one idle cycle after reset or a re-init request
//   LOAD   | write table word ptr into RAM address ptr
//   VERIFY | read back address ptr, compare previous read against table
//   DONE   | RAM port passed through to the user side
//   ERROR  | verify mismatch seen, RAM port idle, err_addr valid
//
// Ports
//   init_clock, init_reset : clock, async active-high reset
//   start                  : re-init request (honoured in DONE/ERROR only)
//   tbl_addr / tbl_data    : init table index and the word it selects
//   usr_addr/usr_din/usr_we: user-side RAM access, live only in DONE
//   ram_addr/ram_din/ram_we: RAM write/read port
//   ram_dout               : RAM read data, one cycle after ram_addr
//   busy/done/error        : state decode
//   err_addr               : address of the first verify mismatch

module ram_init_sequencer #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int INIT_COUNT = 4,
  parameter int VERIFY_EN  = 1
) (
  input  logic              init_clock,
  input  logic              init_reset,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_din,
  input  logic              usr_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  // ptr is one bit wider than an address so it can reach INIT_COUNT when the
  // table fills the whole RAM (the extra verify cycle needs that value).
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(INIT_COUNT - 1);
  localparam logic [ADDR_W:0] PTR_CNT  = (ADDR_W+1)'(INIT_COUNT);

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] exp_data;

  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      state    <= S_BOOT;
      ptr      <= '0;
      err_addr <= '0;
      exp_data <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          ptr   <= '0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          if (ptr == PTR_LAST) begin
            ptr   <= '0;
            state <= (VERIFY_EN != 0) ? S_VERIFY : S_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_VERIFY: begin
          // Read of address ptr is issued this cycle; its data and the table
          // word captured alongside it are compared one cycle later.
          if (ptr < PTR_CNT)
            exp_data <= tbl_data;
          if ((ptr != '0) && (ram_dout != exp_data)) begin
            err_addr <= ptr[ADDR_W-1:0] - 1'b1;
            ptr      <= '0;
            state    <= S_ERROR;
          end else if (ptr == PTR_CNT) begin
            ptr   <= '0;
            state <= S_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            ptr   <= '0;
            state <= S_BOOT;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign tbl_addr = ptr[ADDR_W-1:0];

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_BOOT: busy = 1'b1;
      S_LOAD: begin
        busy     = 1'b1;
        ram_addr = ptr[ADDR_W-1:0];
        ram_din  = tbl_data;
        ram_we   = 1'b1;
      end
      S_VERIFY: begin
        busy     = 1'b1;
        ram_addr = ptr[ADDR_W-1:0];
      end
      S_DONE: begin
        done     = 1'b1;
        ram_addr = usr_addr;
        ram_din  = usr_din;
        ram_we   = usr_we;
      end
      S_ERROR: error = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ram_init_sequencer.sv
// Bench for ram_init_sequencer: default configuration against a behavioural RAM
// with an optional read-back fault, plus an 8-word no-verify instance.

module tb_ram_init_sequencer;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic init_clock = 1'b0;
  always #5 init_clock = ~init_clock;

  logic          init_reset, start, usr_we, ram_we, busy, done, error;
  logic [AW-1:0] tbl_addr, usr_addr, ram_addr, err_addr;
  logic [DW-1:0] tbl_data, usr_din, ram_din, ram_dout;

  logic [DW-1:0] tbl [N];
  logic [DW-1:0] mem [N];
  logic          fault_en;
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] fault_val;

  assign tbl_data = tbl[tbl_addr];

  always @(posedge init_clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= (fault_en && ram_addr == fault_addr) ? fault_val : mem[ram_addr];
  end

  ram_init_sequencer #(.ADDR_W(AW), .DATA_W(DW), .INIT_COUNT(N), .VERIFY_EN(1)) dut (
    .init_clock(init_clock), .init_reset(init_reset), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .usr_addr(usr_addr), .usr_din(usr_din), .usr_we(usr_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  // 8-word, no-verify instance
  logic       rst8, start8, usr_we8, ram_we8, busy8, done8, error8;
  logic [2:0] tbl_addr8, usr_addr8, ram_addr8, err_addr8;
  logic [7:0] tbl_data8, usr_din8, ram_din8, ram_dout8;
  logic [7:0] tbl8 [8];
  logic [7:0] mem8 [8];

  assign tbl_data8 = tbl8[tbl_addr8];

  always @(posedge init_clock) begin
    if (ram_we8) mem8[ram_addr8] <= ram_din8;
    ram_dout8 <= mem8[ram_addr8];
  end

  ram_init_sequencer #(.ADDR_W(3), .DATA_W(8), .INIT_COUNT(8), .VERIFY_EN(0)) dut8 (
    .init_clock(init_clock), .init_reset(rst8), .start(start8),
    .tbl_addr(tbl_addr8), .tbl_data(tbl_data8),
    .usr_addr(usr_addr8), .usr_din(usr_din8), .usr_we(usr_we8),
    .ram_addr(ram_addr8), .ram_din(ram_din8), .ram_we(ram_we8), .ram_dout(ram_dout8),
    .busy(busy8), .done(done8), .error(error8), .err_addr(err_addr8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the first table entry whose read-back differs, or -1.
  function automatic int first_bad();
    if (fault_en && fault_val != tbl[fault_addr]) return int'(fault_addr);
    return -1;
  endfunction

  // Called at the negedge where the DUT sits in BOOT (k = 0). Edge k ends
  // cycle k-1: writes occupy cycles 1..N, verify occupies N+1 cycles, and a
  // mismatch on entry e is seen in verify cycle e+1.
  task automatic run_seq(input bit poke_start);
    int  e;
    int  last_k;
    bit  exp_we, fin_err, fin_done;
    e      = first_bad();
    last_k = (e < 0) ? 2*N + 3 : N + 4 + e;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) @(negedge init_clock);
      exp_we   = (k >= 1 && k <= N);
      fin_err  = (e >= 0 && k >= N + 3 + e);
      fin_done = (e < 0 && k >= 2*N + 2);
      check("ram_we", ram_we, exp_we);
      check("busy", busy, !(fin_err || fin_done));
      check("done", done, fin_done);
      check("error", error, fin_err);
      if (exp_we) begin
        check("wr_addr", ram_addr, k - 1);
        check("wr_data", ram_din, tbl[k-1]);
        check("tbl_addr", tbl_addr, k - 1);
      end
      if (fin_err) begin
        check("err_addr", err_addr, e);
        check("idle_addr", ram_addr, 0);
      end
      usr_addr = AW'($urandom);
      usr_din  = DW'($urandom);
      usr_we   = (k <= N) ? 1'($urandom_range(0, 1)) : 1'b0;
      start    = poke_start && (k == 2);
    end
    start  = 1'b0;
    usr_we = 1'b0;
  endtask

  task automatic kick(input bit via_reset);
    if (via_reset) begin
      init_reset = 1'b1;
      @(negedge init_clock);
      init_reset = 1'b0;
    end else begin
      start = 1'b1;
      @(negedge init_clock);
      start = 1'b0;
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < N; i++) check("ram_content", mem[i], tbl[i]);
  endtask

  task automatic pass_check();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    for (int i = 0; i < 3; i++) begin
      @(negedge init_clock);
      a = AW'($urandom); d = DW'($urandom); w = (i != 1);
      usr_addr = a; usr_din = d; usr_we = w;
      #1;
      check("pt_we", ram_we, w);
      check("pt_addr", ram_addr, a);
      check("pt_din", ram_din, d);
    end
    @(negedge init_clock);
    usr_we = 1'b0;
  endtask

  task automatic rand_table();
    for (int i = 0; i < N; i++) tbl[i] = DW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit via_reset;
    int e;
    init_reset = 1'b1; start = 1'b0;
    usr_addr = '0; usr_din = '0; usr_we = 1'b0;
    fault_en = 1'b0; fault_addr = '0; fault_val = '0;
    rst8 = 1'b1; start8 = 1'b0; usr_addr8 = '0; usr_din8 = '0; usr_we8 = 1'b0;
    tbl[0] = 8'd74; tbl[1] = 8'd29; tbl[2] = 8'd32; tbl[3] = 8'd20;
    for (int i = 0; i < N; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem8[i] = '0;

    repeat (2) @(negedge init_clock);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_err_addr", err_addr, 0);
    init_reset = 1'b0;
    run_seq(1'b0);
    check_mem();
    pass_check();

    // read-back fault at address 2
    fault_en = 1'b1; fault_addr = 2'd2; fault_val = 8'd33;
    kick(1'b0);
    run_seq(1'b0);
    @(negedge init_clock);
    usr_we = 1'b1; usr_addr = 2'd3; usr_din = 8'h55;
    #1;
    check("err_we", ram_we, 0);
    check("err_addr_port", ram_addr, 0);
    check("err_flag", error, 1);
    fault_en = 1'b0;
    usr_we   = 1'b0;
    kick(1'b0);
    check("reboot_busy", busy, 1);
    check("reboot_error", error, 0);
    check("err_addr_held", err_addr, 2);
    run_seq(1'b0);

    // restart from DONE with start poked during LOAD
    rand_table();
    kick(1'b0);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    run_seq(1'b1);
    check_mem();

    for (int it = 0; it < 8; it++) begin
      rand_table();
      fault_en   = 1'($urandom_range(0, 1));
      fault_addr = AW'($urandom);
      fault_val  = ($urandom_range(0, 3) == 0) ? tbl[fault_addr] : DW'($urandom);
      via_reset  = 1'($urandom_range(0, 1));
      e = first_bad();
      kick(via_reset);
      run_seq(1'($urandom_range(0, 1)));
      if (e < 0) check_mem();
    end

    // reset while writing address 2
    fault_en = 1'b0;
    rand_table();
    kick(1'b0);
    repeat (3) @(negedge init_clock);
    check("mid_we", ram_we, 1);
    check("mid_addr", ram_addr, 2);
    #2 init_reset = 1'b1;
    #1;
    check("async_we", ram_we, 0);
    check("async_busy", busy, 1);
    @(negedge init_clock);
    init_reset = 1'b0;
    run_seq(1'b0);
    check_mem();

    // 8-word instance, no verify phase
    for (int i = 0; i < 8; i++) tbl8[i] = 8'($urandom);
    @(negedge init_clock);
    rst8 = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge init_clock);
      check("w8_we", ram_we8, (k >= 1 && k <= 8));
      check("w8_done", done8, (k >= 9));
      check("w8_busy", busy8, (k < 9));
      if (k >= 1 && k <= 8) begin
        check("w8_addr", ram_addr8, k - 1);
        check("w8_data", ram_din8, tbl8[k-1]);
      end
    end
    for (int i = 0; i < 8; i++) check("w8_content", mem8[i], tbl8[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
